// File: rtl/biu_pkg.sv
// Shared AHB-Lite encodings and the SRAM bridge state type.
package biu_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// Byte-lane enables and size/alignment legality for one AHB beat.
module ahb_sram_be_gen
    import biu_pkg::*;
(
    input  logic [2:0] i_haddr_lo,
    input  logic [2:0] i_hsize,
    output logic [7:0] o_be,
    output logic       o_misaligned,
    output logic       o_bad_size
);

    // Lane mask is the transfer width shifted to its byte offset.
    always_comb begin
        o_be         = 8'h00;
        o_misaligned = 1'b0;
        o_bad_size   = 1'b0;
        case (i_hsize)
            HSIZE_BYTE: begin
                o_be = 8'h01 << i_haddr_lo;
            end
            HSIZE_HALF: begin
                o_be         = 8'h03 << i_haddr_lo;
                o_misaligned = i_haddr_lo[0];
            end
            HSIZE_WORD: begin
                o_be         = 8'h0F << i_haddr_lo;
                o_misaligned = |i_haddr_lo[1:0];
            end
            HSIZE_DWORD: begin
                o_be         = 8'hFF;
                o_misaligned = |i_haddr_lo;
            end
            default: begin
                o_bad_size = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave terminating onto a single-port synchronous 64-bit SRAM.
module ahb_sram_bridge
    import biu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [63:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [1:0]        htrans,
    input  logic [63:0]       hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic              hresp,
    output logic [63:0]       hrdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [7:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    localparam int unsigned    CNT_W    = 2;
    localparam logic [63:0]    WIN_END  = BASE_ADDR + (64'd8 << ADDR_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT);

    bridge_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_hreadyout;
    logic              r_hresp;
    logic              r_sram_ce;
    logic              r_sram_we;
    logic [7:0]        r_sram_be;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [63:0]       r_wdata;

    bridge_state_t     w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_hreadyout_nxt;
    logic              w_hresp_nxt;
    logic              w_ce_nxt;
    logic              w_we_nxt;
    logic [7:0]        w_be_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    logic              w_sample;
    logic [63:0]       w_offset;
    logic              w_out_of_range;
    logic [7:0]        w_be;
    logic              w_misaligned;
    logic              w_bad_size;
    logic              w_err;
    logic              w_rd_last;
    logic              w_unused;

    assign w_sample       = hsel & hready_in & htrans[1];
    assign w_offset       = haddr - BASE_ADDR;
    assign w_out_of_range = (haddr < BASE_ADDR) || (haddr >= WIN_END);
    assign w_err          = w_out_of_range | w_misaligned | w_bad_size;
    assign w_rd_last      = (r_state == RD) && (r_cnt == LAST_CNT);
    assign w_unused       = ^{hburst, htrans[0], w_offset[63:ADDR_W+3], w_offset[2:0]};

    ahb_sram_be_gen u_be_gen (
        .i_haddr_lo   (haddr[2:0]),
        .i_hsize      (hsize),
        .o_be         (w_be),
        .o_misaligned (w_misaligned),
        .o_bad_size   (w_bad_size)
    );

    // Next state, wait counter and next values of the registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_ce_nxt    = 1'b0;
        w_we_nxt    = r_sram_we;
        w_be_nxt    = r_sram_be;
        w_addr_nxt  = r_sram_addr;
        case (r_state)
            ERR1: begin
                w_state_nxt = ERR2;
            end
            RD: begin
                if (!w_rd_last) begin
                    w_state_nxt = RD;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A beat can only be accepted in a cycle that finishes the data phase.
        if (w_sample && (r_state != ERR1) && ((r_state != RD) || w_rd_last)) begin
            if (w_err) begin
                w_state_nxt = ERR1;
            end else begin
                w_state_nxt = hwrite ? WR : RD;
                w_ce_nxt    = 1'b1;
                w_we_nxt    = hwrite;
                w_be_nxt    = hwrite ? w_be : 8'hFF;
                w_addr_nxt  = w_offset[ADDR_W+2:3];
            end
        end
        w_hreadyout_nxt = !((w_state_nxt == ERR1) ||
                            ((w_state_nxt == RD) && (w_cnt_nxt != LAST_CNT)));
        w_hresp_nxt     = ((w_state_nxt == ERR1) || (w_state_nxt == ERR2)) ?
                          HRESP_ERROR : HRESP_OKAY;
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_sram_ce   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_sram_be   <= 8'h00;
            r_sram_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            r_sram_ce   <= w_ce_nxt;
            r_sram_we   <= w_we_nxt;
            r_sram_be   <= w_be_nxt;
            r_sram_addr <= w_addr_nxt;
        end
    end

    // Hold the last write data so the SRAM data bus stays quiet between writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdata <= 64'd0;
        end else if (r_state == WR) begin
            r_wdata <= hwdata;
        end
    end

    // Write data arrives in the data phase and goes straight to the SRAM.
    assign sram_wdata = (r_state == WR) ? hwdata : r_wdata;
    assign hrdata     = w_rd_last ? sram_rdata : 64'd0;
    assign hreadyout  = r_hreadyout;
    assign hresp      = r_hresp;
    assign sram_ce    = r_sram_ce;
    assign sram_we    = r_sram_we;
    assign sram_be    = r_sram_be;
    assign sram_addr  = r_sram_addr;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Randomized scoreboard bench for ahb_sram_bridge with a behavioural SRAM.
module tb_ahb_sram_bridge;
    import biu_pkg::*;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned RD_LAT  = 2;
    localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WIN_END = BASE + (64'd8 << ADDR_W);
    localparam int K_WR = 0, K_RD = 1, K_ERR = 2;

    logic              clk, rst, hsel, hwrite, hready_in, hreadyout, hresp;
    logic [63:0]       haddr, hwdata, hrdata, sram_wdata, sram_rdata;
    logic [2:0]        hsize, hburst;
    logic [1:0]        htrans;
    logic              sram_ce, sram_we;
    logic [7:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [63:0] addr;
        logic [63:0] data;
    } xfer_t;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] word;
        logic [7:0]        be;
        logic [63:0]       wdata;
        logic [63:0]       rdata;
    } exp_t;

    xfer_t stim_q[$];
    exp_t  exp_q[$];
    logic [63:0] ref_mem [logic [ADDR_W-1:0]];
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic mon_active = 1'b0;
    int   mon_cyc = 0;
    exp_t mon_cur;

    assign hready_in = hreadyout;

    ahb_sram_bridge #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hready_in(hready_in), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked writes, reads return RD_LAT cycles after the strobe.
    logic [63:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [63:0] rd_pipe  [0:2];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] <= 64'd0;
        end else if (sram_ce && sram_we) begin
            for (int b = 0; b < 8; b++)
                if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (sram_ce && !sram_we) ? sram_mem[sram_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int exp_len(input int kind);
        if (kind == K_WR) return 1;
        if (kind == K_RD) return RD_LAT + 1;
        return 2;
    endfunction

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [2:0] burst,
                                 input logic [63:0] addr, input logic [63:0] data);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size;
        x.burst = burst; x.addr = addr; x.data = data;
        return x;
    endfunction

    task automatic apply(input xfer_t x);
        hsel = x.sel; htrans = x.trans; hwrite = x.wr;
        hsize = x.size; hburst = x.burst; haddr = x.addr;
    endtask

    // Reference model: bus-level rules applied in program order to a word array.
    task automatic predict(input xfer_t x);
        exp_t        e;
        int unsigned nbytes;
        logic [63:0] cur;
        e.kind = K_ERR; e.word = '0; e.be = 8'h00; e.wdata = 64'd0; e.rdata = 64'd0;
        if (!(x.addr < BASE || x.addr >= WIN_END || x.size > 3 ||
              (x.addr % (64'd1 << x.size)) != 0)) begin
            nbytes = 1 << x.size;
            e.word = ADDR_W'((x.addr - BASE) / 8);
            e.be   = 8'(((1 << nbytes) - 1) << (x.addr % 8));
            cur    = ref_mem.exists(e.word) ? ref_mem[e.word] : 64'd0;
            if (x.wr) begin
                e.kind  = K_WR;
                e.wdata = x.data;
                for (int b = 0; b < 8; b++)
                    if (e.be[b]) cur[8*b +: 8] = x.data[8*b +: 8];
                ref_mem[e.word] = cur;
            end else begin
                e.kind  = K_RD;
                e.be    = 8'hFF;
                e.rdata = cur;
            end
        end
        exp_q.push_back(e);
    endtask

    // Pipelined AHB master: holds the address phase while the slave stalls.
    task automatic run_stim();
        xfer_t a;
        logic  rdy_prev, rdy_now;
        int    stall;
        a = mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        apply(a);
        rdy_prev = 1'b1;
        stall = 0;
        while (1) begin
            @(posedge clk); #1;
            rdy_now = hreadyout;
            if (rdy_prev) begin
                stall = 0;
                if (a.sel && a.trans[1] && a.wr) hwdata = a.data;
                if (stim_q.size() == 0) break;
                a = stim_q.pop_front();
                apply(a);
            end else begin
                stall++;
                if (stall > 20) begin
                    checks++; errors++;
                    $display("FAIL driver_stall actual=hreadyout_low required=ready_within_20");
                    break;
                end
            end
            if (rdy_now && a.sel && a.trans[1]) predict(a);
            rdy_prev = rdy_now;
        end
        apply(mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hreadyout"},  64'(hreadyout),  64'd1);
        chk({tag, "_hresp"},      64'(hresp),      64'd0);
        chk({tag, "_hrdata"},     hrdata,          64'd0);
        chk({tag, "_sram_ce"},    64'(sram_ce),    64'd0);
        chk({tag, "_sram_we"},    64'(sram_we),    64'd0);
        chk({tag, "_sram_be"},    64'(sram_be),    64'd0);
        chk({tag, "_sram_addr"},  64'(sram_addr),  64'd0);
        chk({tag, "_sram_wdata"}, sram_wdata,      64'd0);
    endtask

    // Monitor: pops an expectation on every accepted beat and checks its data phase.
    initial begin
        logic done;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst) begin
                mon_active = 1'b0;
            end else begin
                if (mon_active) begin
                    mon_cyc++;
                    if (mon_cyc == 1 && mon_cur.kind != K_ERR) begin
                        chk("strobe_ce",   64'(sram_ce), 64'd1);
                        chk("strobe_we",   64'(sram_we), (mon_cur.kind == K_WR) ? 64'd1 : 64'd0);
                        chk("strobe_addr", 64'(sram_addr), 64'(mon_cur.word));
                        chk("strobe_be",   64'(sram_be), 64'(mon_cur.be));
                        if (mon_cur.kind == K_WR) chk("strobe_wdata", sram_wdata, mon_cur.wdata);
                    end else begin
                        chk("no_strobe", 64'(sram_ce), 64'd0);
                    end
                    done = hreadyout;
                    chk("dp_hresp", 64'(hresp), (mon_cur.kind == K_ERR) ? 64'd1 : 64'd0);
                    chk("dp_hrdata", hrdata, (done && mon_cur.kind == K_RD) ? mon_cur.rdata : 64'd0);
                    if (done) begin
                        chk("dp_len", 64'(mon_cyc), 64'(exp_len(mon_cur.kind)));
                        mon_active = 1'b0;
                    end else if (mon_cyc > int'(RD_LAT) + 4) begin
                        checks++; errors++;
                        $display("FAIL dp_timeout actual=%0d_cycles required=%0d", mon_cyc, exp_len(mon_cur.kind));
                        mon_active = 1'b0;
                    end
                end else begin
                    chk("idle_ready_resp_ce", {61'd0, hreadyout, hresp, sram_ce}, 64'd4);
                    chk("idle_hrdata", hrdata, 64'd0);
                end
                if (hreadyout && hsel && htrans[1]) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL accept_unexpected actual=beat_accepted required=no_pending");
                    end else begin
                        mon_cur    = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_cyc    = 0;
                    end
                end
            end
        end
    end

    initial begin
        xfer_t x;
        int    r;
        rst = 1'b0;
        apply(mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0));
        hwdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;
        mon_en = 1'b1;

        // Directed beats: aligned write/read-back, byte/halfword lanes, errors.
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 3'd0, 64'h8000_0010, 64'h1122_3344_5566_7788));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 3'd0, 64'h8000_0010, 64'd0));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,  3'd0, 64'h8000_0013, 64'hA5A5_A5A5_A5A5_A5A5));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF,  3'd0, 64'h8000_0016, 64'h5A5A_5A5A_5A5A_5A5A));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 3'd0, 64'h8000_0010, 64'd0));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 3'd0, 64'h8008_0000, 64'hDEAD));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  3'd0, 64'h8000_0002, 64'd0));
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd4,        3'd0, 64'h8000_0000, 64'd0));
        // INCR4 read burst with a BUSY and deselected cycles mixed in.
        stim_q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 3'd3, 64'h8000_0000, 64'd0));
        stim_q.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_DWORD, 3'd3, 64'h8000_0008, 64'd0));
        stim_q.push_back(mk(1, HTRANS_BUSY,   0, HSIZE_DWORD, 3'd3, 64'h8000_0010, 64'd0));
        stim_q.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_DWORD, 3'd3, 64'h8000_0010, 64'd0));
        stim_q.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_DWORD, 3'd3, 64'h8000_0018, 64'd0));
        stim_q.push_back(mk(0, HTRANS_NONSEQ, 1, HSIZE_DWORD, 3'd0, 64'h8000_0020, 64'd0));
        stim_q.push_back(mk(1, HTRANS_IDLE,   1, HSIZE_DWORD, 3'd0, 64'h8000_0020, 64'd0));

        // Random beats concentrated near the window bottom and both window edges.
        for (int n = 0; n < 400; n++) begin
            x.sel = ($urandom_range(0, 99) < 92);
            r = int'($urandom_range(0, 99));
            x.trans = (r < 60) ? HTRANS_NONSEQ : (r < 80) ? HTRANS_SEQ :
                      (r < 90) ? HTRANS_BUSY : HTRANS_IDLE;
            x.wr    = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            x.burst = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 99));
            if (r < 6)       x.addr = BASE - 64'($urandom_range(1, 64));
            else if (r < 12) x.addr = WIN_END - 64'd16 + 64'($urandom_range(0, 31));
            else             x.addr = BASE + 64'($urandom_range(0, 255));
            if (x.size <= 3 && $urandom_range(0, 4) != 0)
                x.addr = x.addr & ~((64'd1 << x.size) - 64'd1);
            x.data = {$urandom, $urandom};
            stim_q.push_back(x);
        end

        run_stim();
        for (int i = 0; i < 20 && (exp_q.size() > 0 || mon_active); i++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        chk("drain_active",  64'(mon_active), 64'd0);

        // Reset asserted in the read wait cycle aborts the transfer.
        mon_en = 1'b0;
        @(posedge clk); #1;
        apply(mk(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 3'd0, 64'h8000_0010, 64'd0));
        @(posedge clk); #1;
        chk("rstrd_ce",  64'(sram_ce), 64'd1);
        chk("rstrd_rdy", 64'(hreadyout), 64'd0);
        apply(mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0));
        @(posedge clk); #1;
        chk("rstrd_wait_rdy", 64'(hreadyout), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("rstrd");
        ref_mem.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy",    64'(hreadyout), 64'd1);
        chk("post_rst_hrdata", hrdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_bridge.md
# ahb_sram_bridge

AHB-Lite slave that terminates the CPU bus interface's AHB master port (through the bus arbiter) onto a single-port synchronous 64-bit on-chip SRAM. Each accepted beat becomes one SRAM operation issued in the first data-phase cycle:

- Writes complete with zero wait states.
- Reads insert `RD_LAT` wait states.
- Out-of-range, oversize and misaligned accesses get the two-cycle AHB ERROR response and never touch the SRAM.

## Interface
Clocking: single clock `clk`; reset `rst` is synchronous and active-low (all state reset on the `clk` edge where `rst`=0).

Parameters:
- `ADDR_W`, 16: SRAM word-address width; window is 8·2^ADDR_W bytes.
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte base of the window; must be 8-byte aligned.
- `RD_LAT`, 1: SRAM read latency in cycles, 1..3.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-low reset
- `hsel`  in  1  slave select
- `haddr`  in  64  address
- `hwrite`  in  1  1 = write
- `hsize`  in  3  0/1/2/3 = 1/2/4/8 bytes; 4..7 illegal
- `hburst`  in  3  accepted, ignored (every beat carries its own address)
- `htrans`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hwdata`  in  64  write data, little-endian lanes
- `hready_in`  in  1  bus-wide HREADY
- `hreadyout`  out  1  slave ready
- `hresp`  out  1  0 = OKAY, 1 = ERROR
- `hrdata`  out  64  read data, full word
- `sram_ce`  out  1  SRAM access strobe
- `sram_we`  out  1  1 = write
- `sram_be`  out  8  byte enables
- `sram_addr`  out  ADDR_W  word address = (haddr−BASE_ADDR)[ADDR_W+2:3]
- `sram_wdata`  out  64  write data
- `sram_rdata`  in  64  valid RD_LAT cycles after a read strobe

## Operation
**Address-phase sample.** An address phase is sampled when `hsel`·`hready_in`·`htrans[1]` is true. The bridge registers addr, write, size and an error flag.

**Error flag.** Set if any of the following holds:
- `haddr` < `BASE_ADDR`
- `haddr` ≥ `BASE_ADDR` + 8·2^ADDR_W
- `hsize` > 3
- `haddr` not aligned to 2^hsize

**Byte enables.** `be` = ((1<<(1<<hsize))−1) << haddr[2:0].

**IDLE/BUSY.** IDLE/BUSY transfers and `hsel`=0 produce no data-phase state: OKAY with zero wait.

**FSM states:**
- `IDLE`
  - `hreadyout`=1, `hresp`=0.
  - On a sample: error → `ERR1`; write → `WR`; read → `RD`.
- `WR` (one cycle)
  - Drives `sram_ce`=1, `sram_we`=1, `sram_be`=be, `sram_addr`, `sram_wdata`=`hwdata`; `hreadyout`=1.
  - Next state: the new sample's target, else `IDLE`.
- `RD`
  - In the first cycle: `sram_ce`=1, `sram_we`=0, `sram_be`=8'hFF.
  - A wait counter runs from 0 while `hreadyout`=0.
  - In cycle RD_LAT: `hreadyout`=1, `hrdata`=`sram_rdata`.
  - Next state: the new sample's target, else `IDLE`.
- `ERR1`
  - `hreadyout`=0, `hresp`=1; always → `ERR2`.
- `ERR2`
  - `hreadyout`=1, `hresp`=1.
  - Next state: the new sample's target, else `IDLE`. A transfer the master does not cancel is honoured.

**Unsampled cycles.** Address phases presented while `hreadyout`=0 are not sampled, because `hready_in` is low.

**Idle outputs.** `hrdata` = 0 in every cycle that does not complete a read. SRAM outputs other than `sram_ce` hold their last value; `sram_ce`=0 outside `WR` and the first `RD` cycle.

**Ignored inputs.** `hburst` and any locked sequence need no special handling.

## Timing
**Write.** Data phase 1 cycle; the SRAM write occurs in the data-phase cycle, with `hwdata` sampled there. Back-to-back writes run at 1 beat/cycle.

**Read.** Data phase is RD_LAT+1 cycles; throughput is 1 beat per RD_LAT+1 cycles.

**Write→read, same address.** The read's SRAM strobe falls at least one cycle after the write, so it returns the new data. No bypass is needed.

**Error.** Exactly 2 cycles. Zero SRAM strobes.

**Reset values:**
- `hreadyout`=1, `hresp`=0, `hrdata`=0.
- `sram_ce`=0, `sram_we`=0, `sram_be`=0, `sram_addr`=0, `sram_wdata`=0.
- state = `IDLE`, wait counter = 0.

**Reset mid-transfer.** Reset asserted during `RD`/`ERR1` aborts: the next cycle is `IDLE` with reset values. A returning `sram_rdata` is ignored.

## Structure
**Shared package `biu_pkg`:**
- htrans codes
- hsize codes
- hresp codes
- bridge state enum (`IDLE`, `WR`, `RD`, `ERR1`, `ERR2`)

**Sub-module `ahb_sram_be_gen`** (combinational): inputs `haddr[2:0]` and `hsize`; outputs `be[7:0]` and `misaligned`/`bad_size`.

**Top level:** range compare, FSM, wait counter and output registers.

## Test plan
1. **Aligned write.** NONSEQ write, hsize=3, haddr=0x8000_0010, hwdata=0x1122334455667788 → `sram_ce`/`sram_we`=1, `sram_addr`=2, `sram_be`=0xFF, in the data cycle with `hreadyout`=1. A following read returns 0x1122334455667788 after 1 wait cycle (RD_LAT=1).
2. **Byte write.** hsize=0, haddr=0x8000_0013 → `sram_be`=0x08. Halfword at 0x8000_0016 → `sram_be`=0xC0.
3. **Errors.** Each case → `ERR1` (`hreadyout`=0, `hresp`=1) then `ERR2` (`hreadyout`=1, `hresp`=1), with `sram_ce` never asserted:
   - haddr=0x8008_0000 with ADDR_W=16 (out of range)
   - hsize=2 at 0x8000_0002 (misaligned)
   - hsize=4 (illegal size)
4. **INCR4 read burst.** Reads from 0x8000_0000 with RD_LAT=2 → 4 beats, 3 cycles each, `sram_addr`=0,1,2,3.
5. **IDLE/BUSY mixed in.** BUSY inserted mid-burst and `hsel`=0 cycles → `hreadyout`=1, `hresp`=0, no `sram_ce`.
6. **Reset during read.** `rst`=0 during the `RD` wait cycle → next cycle `IDLE`, all outputs at reset values, `hrdata`=0.
